// File: rtl/dcache_sb_drain.sv
// -----------------------------------------------------------------------------
// dcache_sb_drain
//   Commit-side engine that retires the oldest store-buffer entry into the
//   dcache. Hits are written straight into the data/tag SRAMs through port 1.
//   Misses run an optional dirty-victim writeback followed by a line refill
//   over a simple memory bus. Uncached stores become a single bus write beat.
//
//   Optional build macro: DCACHE_DRAIN_PERF_EN adds saturating 32-bit
//   hit/miss/writeback event counters (hit_cnt_o, miss_cnt_o, wb_cnt_o).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               pipeline flush (no effect: only committed stores)
//   sb_*_i                head store-buffer entry plus its M1 tag lookup
//   resp_data_i           port-1 data-SRAM read data, one cycle after address
//   req_*_o, fetch_sb_o   port-1 SRAM request and store-buffer pop
//   mem_*                 memory bus request / write beat / read beat channels
//                         (mem_rlast_i also acknowledges write completion)
//   busy_o                engine not idle
// -----------------------------------------------------------------------------
module dcache_sb_drain #(
  parameter int WAY_NUM    = 2,
  parameter int LINE_WORDS = 4,
  parameter int IDX_LOW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  sb_valid_i,
  input  logic [31:0]           sb_addr_i,
  input  logic [31:0]           sb_data_i,
  input  logic [3:0]            sb_strb_i,
  input  logic                  sb_uncached_i,
  input  logic [WAY_NUM-1:0]    sb_hit_i,
  input  logic [WAY_NUM-1:0]    sb_dirty_i,
  input  logic [WAY_NUM*20-1:0] sb_vtag_i,
  input  logic [32*WAY_NUM-1:0] resp_data_i,
  output logic [31:0]           req_addr_o,
  output logic [WAY_NUM-1:0]    req_way_o,
  output logic                  req_tag_we_o,
  output logic [21:0]           req_tag_o,
  output logic [3:0]            req_strb_o,
  output logic [31:0]           req_data_o,
  output logic                  fetch_sb_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [31:0]           mem_req_addr_o,
  output logic [1:0]            mem_req_len_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_rlast_i,
  output logic                  busy_o
`ifdef DCACHE_DRAIN_PERF_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o,
  output logic [31:0]           wb_cnt_o
`endif
);

  localparam int WOFF_W   = $clog2(LINE_WORDS);
  localparam int LINE_LSB = WOFF_W + 2;
  localparam int CNT_W    = WOFF_W + 1;
  localparam int VW       = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LINE = CNT_W'(LINE_WORDS);
  localparam logic [VW-1:0]    WAY_LAST = VW'(WAY_NUM - 1);

  typedef enum logic [3:0] {
    IDLE, HIT_WR, WB_RD, WB_REQ, WB_DATA, RF_REQ, RF_DATA, TAG_WR, UC_REQ, UC_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // word/beat counter, also UC "beat sent" flag
  logic [VW-1:0]    way_q, way_d;        // way being replaced for the current miss
  logic [VW-1:0]    victim_q, victim_d;  // round-robin replacement pointer

  logic [31:0]        wb_buf_q [LINE_WORDS];
  logic               buf_we;
  logic [WOFF_W-1:0]  buf_idx;

  logic [WAY_NUM-1:0] way_oh;
  logic [31:0]        line_base, word_addr, resp_word, merged_word;
  logic [19:0]        victim_tag;
  logic               w_fire;

  // Only committed stores live in the store buffer, so a flush never affects it.
  logic unused_flush;
  assign unused_flush = flush_i;

  assign line_base  = {sb_addr_i[31:LINE_LSB], {LINE_LSB{1'b0}}};
  assign word_addr  = {sb_addr_i[31:LINE_LSB], cnt_q[WOFF_W-1:0], 2'b00};
  assign resp_word  = resp_data_i[32*way_q +: 32];
  assign victim_tag = sb_vtag_i[20*way_q +: 20];
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    way_oh         = '0;
    way_oh[way_q]  = 1'b1;
  end

  // Refill beat with the pending store's bytes overlaid.
  always_comb begin
    merged_word = mem_rdata_i;
    for (int b = 0; b < 4; b++) begin
      if (sb_strb_i[b]) merged_word[8*b +: 8] = sb_data_i[8*b +: 8];
    end
  end

  // NOTE: every output and _d signal gets a default before the case so that no
  // path through the FSM leaves a value unassigned and infers a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    way_d           = way_q;
    victim_d        = victim_q;
    buf_we          = 1'b0;
    buf_idx         = WOFF_W'(cnt_q - CNT_ONE);
    w_fire          = 1'b0;
    req_addr_o      = '0;
    req_way_o       = '0;
    req_tag_we_o    = 1'b0;
    req_tag_o       = '0;
    req_strb_o      = '0;
    req_data_o      = '0;
    fetch_sb_o      = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_len_o   = '0;
    mem_wdata_o     = '0;
    mem_wstrb_o     = '0;
    mem_wvalid_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sb_valid_i) begin
          if (sb_uncached_i) begin
            state_d = UC_REQ;
          end else if (|sb_hit_i) begin
            state_d = HIT_WR;
          end else begin
            way_d   = victim_q;
            state_d = sb_dirty_i[victim_q] ? WB_RD : RF_REQ;
          end
        end
      end

      HIT_WR: begin
        req_addr_o   = sb_addr_i;
        req_way_o    = sb_hit_i;
        req_strb_o   = sb_strb_i;
        req_data_o   = sb_data_i;
        req_tag_we_o = 1'b1;
        req_tag_o    = {sb_addr_i[31:12], 2'b11};
        fetch_sb_o   = 1'b1;
        state_d      = IDLE;
      end

      // Reads go out for cnt 0..LINE_WORDS-1; each word returns one cycle
      // later, so the capture trails the address by one and needs one extra cycle.
      WB_RD: begin
        if (cnt_q != CNT_LINE) begin
          req_addr_o = word_addr;
          req_way_o  = way_oh;
        end
        buf_we = (cnt_q != '0);
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LINE) begin
          cnt_d   = '0;
          state_d = WB_REQ;
        end
      end

      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {victim_tag, sb_addr_i[11:IDX_LOW], {IDX_LOW{1'b0}}};
        mem_req_len_o   = 2'(LINE_WORDS - 1);
        if (mem_req_ready_i) state_d = WB_DATA;
      end

      // After the last beat, the bus acknowledges completion with mem_rlast_i.
      WB_DATA: begin
        if (cnt_q != CNT_LINE) begin
          mem_wvalid_o = 1'b1;
          mem_wdata_o  = wb_buf_q[cnt_q[WOFF_W-1:0]];
          mem_wstrb_o  = 4'hF;
        end
        w_fire = mem_wvalid_o & mem_wready_i;
        if (w_fire) cnt_d = cnt_q + CNT_ONE;
        if (mem_rlast_i && ((cnt_q == CNT_LINE) || (w_fire && cnt_q == CNT_LAST))) begin
          cnt_d   = '0;
          state_d = RF_REQ;
        end
      end

      RF_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = line_base;
        mem_req_len_o   = 2'(LINE_WORDS - 1);
        if (mem_req_ready_i) state_d = RF_DATA;
      end

      RF_DATA: begin
        if (mem_rvalid_i) begin
          req_addr_o = word_addr;
          req_way_o  = way_oh;
          req_strb_o = 4'hF;
          req_data_o = (cnt_q[WOFF_W-1:0] == sb_addr_i[LINE_LSB-1:2]) ? merged_word
                                                                       : mem_rdata_i;
          cnt_d      = cnt_q + CNT_ONE;
          if (mem_rlast_i) begin
            cnt_d   = '0;
            state_d = TAG_WR;
          end
        end
      end

      TAG_WR: begin
        req_addr_o   = line_base;
        req_way_o    = way_oh;
        req_tag_we_o = 1'b1;
        req_tag_o    = {sb_addr_i[31:12], 2'b11};
        fetch_sb_o   = 1'b1;
        victim_d     = (victim_q == WAY_LAST) ? '0 : victim_q + VW'(1);
        state_d      = IDLE;
      end

      UC_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = sb_addr_i;
        if (mem_req_ready_i) state_d = UC_WAIT;
      end

      // cnt_q == 0: beat still pending; otherwise waiting for the acknowledge.
      UC_WAIT: begin
        if (cnt_q == '0) begin
          mem_wvalid_o = 1'b1;
          mem_wdata_o  = sb_data_i;
          mem_wstrb_o  = sb_strb_i;
        end
        w_fire = mem_wvalid_o & mem_wready_i;
        if (w_fire) cnt_d = CNT_ONE;
        if (mem_rlast_i && (cnt_q != '0 || w_fire)) begin
          fetch_sb_o = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      way_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      way_q    <= way_d;
      victim_q <= victim_d;
    end
  end

  // NOTE: the writeback buffer is plain storage without reset; every word is
  // written in WB_RD before WB_DATA can read it.
  always_ff @(posedge clk) begin
    if (buf_we) wb_buf_q[buf_idx] <= resp_word;
  end

`ifdef DCACHE_DRAIN_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    hit_cnt_d  = sat_inc(hit_cnt_q, state_q == HIT_WR);
    miss_cnt_d = sat_inc(miss_cnt_q, state_d == RF_REQ && state_q != RF_REQ);
    wb_cnt_d   = sat_inc(wb_cnt_q, state_d == WB_REQ && state_q != WB_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: doc/dcache_sb_drain.md
Name: dcache_sb_drain

Overview:
- Commit-side engine that retires the oldest store-buffer entry into the dcache.
- Drives the dcache's port-1 (commit) request: tag/data SRAM writes plus the store-buffer pop (fetch_sb). Consumes the dcache's port-1 response: 1-cycle-late SRAM read data and the head store-buffer entry.
- On a miss it performs dirty-victim writeback and a 4-word line refill over a simple memory bus. Uncached stores go straight to the bus.

Parameters:
- WAY_NUM, 2, number of cache ways; victim is selected round-robin.
- LINE_WORDS, 4, 32-bit words per cache line.
- IDX_LOW, 4, lowest address bit of the set index; the index is addr[11:IDX_LOW].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; does not abort an in-progress line operation
- sb_valid_i  in  1  head store-buffer entry is valid
- sb_addr_i  in  32  entry physical address
- sb_data_i  in  32  entry write data
- sb_strb_i  in  4  entry byte strobes
- sb_uncached_i  in  1  entry is uncached
- sb_hit_i  in  WAY_NUM  one-hot tag hit recorded at M1
- sb_dirty_i  in  WAY_NUM  dirty bit of each way at this entry's set
- sb_vtag_i  in  WAY_NUM*20  tag of each way at this entry's set
- resp_data_i  in  32*WAY_NUM  port-1 data-SRAM read data, valid 1 cycle after address
- req_addr_o  out  32  port-1 SRAM address
- req_way_o  out  WAY_NUM  port-1 way select
- req_tag_we_o  out  1  tag write enable
- req_tag_o  out  22  tag write data {tag[19:0], d, v}
- req_strb_o  out  4  data-SRAM byte write enables
- req_data_o  out  32  data-SRAM write data
- fetch_sb_o  out  1  single-cycle store-buffer pop
- mem_req_valid_o  out  1  bus request valid
- mem_req_ready_i  in  1  bus request accepted
- mem_req_we_o  out  1  1 = write, 0 = read
- mem_req_addr_o  out  32  bus address
- mem_req_len_o  out  2  beats minus one (3 = line, 0 = single)
- mem_wdata_o  out  32  write beat data
- mem_wstrb_o  out  4  write beat strobe
- mem_wvalid_o  out  1  write beat valid
- mem_wready_i  in  1  write beat accepted
- mem_rvalid_i  in  1  read beat valid
- mem_rdata_i  in  32  read beat data
- mem_rlast_i  in  1  last read beat; also used as the write-complete acknowledge
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, victim pointer to way 0, beat counter to 0.
- IDLE:
  - sb_valid_i & sb_uncached_i -> UC_REQ.
  - sb_valid_i & |sb_hit_i -> HIT_WR.
  - sb_valid_i, otherwise -> latch victim way v; go to WB_RD if sb_dirty_i[v], else RF_REQ.
- HIT_WR (1 cycle):
  - req_way_o = sb_hit_i, req_strb_o = sb_strb_i, req_data_o = sb_data_i.
  - Tag write with d=1, v=1, tag = sb_addr_i[31:12].
  - fetch_sb_o = 1, then -> IDLE.
  - Store latency is 2 cycles from IDLE acceptance.
- WB_RD: issue LINE_WORDS reads on port 1 at line base, words 0..3. Capture resp_data_i[v] one cycle later into a 4-word buffer, then -> WB_REQ.
- WB_REQ:
  - mem_req_we_o = 1, address = {sb_vtag_i[v], index, 4'b0}, len = 3.
  - Hold the request until mem_req_ready_i, then -> WB_DATA.
- WB_DATA: stream 4 beats with wstrb = 4'hF, advancing only on mem_wvalid_o & mem_wready_i. The final beat must be accepted and mem_rlast_i seen before -> RF_REQ.
- RF_REQ: read request, address = line base of sb_addr_i, len = 3. On mem_req_ready_i -> RF_DATA.
- RF_DATA:
  - Each mem_rvalid_i writes one word into way v (strb = 4'hF) at beat index.
  - The store's own word is merged with sb_strb_i/sb_data_i before the SRAM write.
  - On mem_rlast_i -> TAG_WR.
- TAG_WR (1 cycle):
  - Tag write {sb_addr_i[31:12], d=1, v=1} to way v.
  - fetch_sb_o = 1, victim pointer advances (wraps at WAY_NUM-1 -> 0), then -> IDLE.
- UC_REQ / UC_WAIT:
  - Single-beat write (len = 0) with sb_strb_i.
  - After the beat is accepted, wait for mem_rlast_i; then fetch_sb_o = 1 and -> IDLE.
- The head entry is held stable by the store buffer until fetch_sb_o. The block never pops twice for one entry.
- mem_rvalid_i outside RF_DATA and UC_WAIT is ignored.
- flush_i: ignored in every state (the store buffer holds only committed stores).
- Asynchronous reset mid-line: FSM aborts and returns to the reset state immediately.
- Any write enable is asserted for exactly one cycle per word.

Optional Feature:
- DCACHE_DRAIN_PERF_EN: when defined, adds three 32-bit output counters:
  - hit_cnt_o, incremented on HIT_WR.
  - miss_cnt_o, incremented on entry to RF_REQ.
  - wb_cnt_o, incremented on entry to WB_REQ.
- Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, none of these ports or registers exist.

Test Plan:
- Cached hit: sb_hit_i=2'b10, addr 0x0000_1234, data 0xDEADBEEF, strb 4'b0011 -> next cycle req_way_o=2'b10, req_strb_o=4'b0011, req_tag_o={20'h00001, 1, 1}, fetch_sb_o=1 for one cycle; no bus activity.
- Clean miss: hit 0, victim 0 clean, addr 0x8000_0040 -> read at 0x8000_0040 len=3; 4 beats 0x11..0x44 written to way 0 words 0..3 with the store merged; tag write, pop, victim pointer = 1.
- Dirty miss: victim 1 dirty, vtag 0x12345, index 0x04 -> write request at 0x1234_5040 with 4 beats equal to the buffered line, then refill, then pop.
- Uncached store: addr 0x1FD0_0000, strb 4'h1 -> single write beat len=0, wstrb=4'h1; pop only after mem_rlast_i.
- Backpressure: mem_req_ready_i low 5 cycles and mem_wready_i toggling -> request held stable, no beat lost or duplicated, exactly one fetch_sb_o.
- Async reset asserted during RF_DATA beat 2 -> all outputs 0 immediately, FSM in IDLE, victim pointer reset to way 0.
